// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - state encodings, error codes and delimiter shared by the "&&payload&&" UART framing blocks
package uart_frame_pkg;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_SOF1    = 5'b00010,
        ST_PAYLOAD = 5'b00100,
        ST_EOF1    = 5'b01000,
        ST_DONE    = 5'b10000
    } state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_OVERFLOW = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd2;
    localparam logic [2:0] ERR_EMPTY    = 3'd3;
    localparam logic [2:0] ERR_CHECKSUM = 3'd4;

    localparam logic [7:0] DEFAULT_DELIM = 8'h26;

endpackage

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - "&&payload&&" byte-stream decoder into a flat payload buffer
// Optional trailing XOR checksum byte: define UART_FRAME_RX_CHECKSUM_EN.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN     = 64,
    parameter logic [7:0] DELIM       = DEFAULT_DELIM,
    parameter int         TIMEOUT_CLK = 50_000
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_vld,
    output logic [8*MAX_LEN-1:0]   frame_data,
    output logic [7:0]             frame_len,
    output logic                   frame_vld,
    output logic                   frame_err,
    output logic [2:0]             err_code,
    output logic                   busy
);

    localparam int BW = 8 * MAX_LEN;
    localparam int IW = (BW > 1) ? $clog2(BW) : 1;
    localparam int TW = $clog2(TIMEOUT_CLK + 1);

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [BW-1:0]   frame_data_q, frame_data_d;
    logic [7:0]      frame_len_q, frame_len_d;
    logic            frame_vld_q, frame_vld_d;
    logic            frame_err_q, frame_err_d;
    logic [2:0]      err_code_q, err_code_d;
`ifdef UART_FRAME_RX_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    logic            is_delim;
    logic            timeout_hit;
    logic [7:0]      cnt_inc;
    logic [IW-1:0]   idx0, idx1;

    assign is_delim    = rx_vld && (rx_byte == DELIM);
    assign timeout_hit = !rx_vld && (timer_q == TW'(TIMEOUT_CLK - 1));
    assign cnt_inc     = cnt_q + 8'd1;
    assign idx0        = IW'({cnt_q, 3'b000});
    assign idx1        = IW'({cnt_inc, 3'b000});

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        frame_data_d = frame_data_q;
        frame_len_d  = frame_len_q;
        frame_vld_d  = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = ERR_NONE;
`ifdef UART_FRAME_RX_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        if (rx_vld || state_q == ST_IDLE) timer_d = '0;
        else                              timer_d = timer_q + TW'(1);

        case (state_q)
            ST_IDLE: begin
                if (is_delim) state_d = ST_SOF1;
            end
            ST_SOF1: begin
                if (is_delim) begin
                    state_d = ST_PAYLOAD;
                    cnt_d   = 8'd0;
`ifdef UART_FRAME_RX_CHECKSUM_EN
                    csum_d  = 8'd0;
`endif
                end else if (rx_vld || timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (is_delim) begin
                    state_d = ST_EOF1;
                end else if (rx_vld) begin
                    if ({1'b0, cnt_q} >= 9'(MAX_LEN)) begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_OVERFLOW;
                    end else begin
                        buf_d[idx0 +: 8] = rx_byte;
                        cnt_d            = cnt_inc;
`ifdef UART_FRAME_RX_CHECKSUM_EN
                        csum_d           = csum_q ^ rx_byte;
`endif
                    end
                end else if (timeout_hit) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                end
            end
            ST_EOF1: begin
                if (is_delim) begin
                    state_d = ST_DONE;
                end else if (rx_vld) begin
                    // a lone delimiter followed by data is payload: store both bytes
                    if ({1'b0, cnt_q} + 9'd2 > 9'(MAX_LEN)) begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_OVERFLOW;
                    end else begin
                        buf_d[idx0 +: 8] = DELIM;
                        buf_d[idx1 +: 8] = rx_byte;
                        cnt_d            = cnt_q + 8'd2;
                        state_d          = ST_PAYLOAD;
`ifdef UART_FRAME_RX_CHECKSUM_EN
                        csum_d           = csum_q ^ DELIM ^ rx_byte;
`endif
                    end
                end else if (timeout_hit) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef UART_FRAME_RX_CHECKSUM_EN
                // running XOR over data plus checksum byte is zero on a match
                if (cnt_q <= 8'd1) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_EMPTY;
                end else if (csum_q != 8'd0) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_CHECKSUM;
                end else begin
                    frame_data_d = buf_q;
                    frame_len_d  = cnt_q - 8'd1;
                    frame_vld_d  = 1'b1;
                end
`else
                if (cnt_q == 8'd0) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_EMPTY;
                end else begin
                    frame_data_d = buf_q;
                    frame_len_d  = cnt_q;
                    frame_vld_d  = 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            buf_q        <= '0;
            timer_q      <= '0;
            frame_data_q <= '0;
            frame_len_q  <= 8'd0;
            frame_vld_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
`ifdef UART_FRAME_RX_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            timer_q      <= timer_d;
            frame_data_q <= frame_data_d;
            frame_len_q  <= frame_len_d;
            frame_vld_q  <= frame_vld_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
`ifdef UART_FRAME_RX_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign frame_data = frame_data_q;
    assign frame_len  = frame_len_q;
    assign frame_vld  = frame_vld_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - self-checking bench for uart_frame_rx with a byte-level framing reference model
module tb_uart_frame_rx;

    localparam int         ML = 64;
    localparam int         TO = 200;
    localparam logic [7:0] DL = 8'h26;

    logic                sys_clk = 1'b0;
    logic                sys_rst_n = 1'b0;
    logic [7:0]          rx_byte = 8'h00;
    logic                rx_vld = 1'b0;
    logic [8*ML-1:0]     frame_data;
    logic [7:0]          frame_len;
    logic                frame_vld;
    logic                frame_err;
    logic [2:0]          err_code;
    logic                busy;

    uart_frame_rx #(.MAX_LEN(ML), .DELIM(DL), .TIMEOUT_CLK(TO)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_byte(rx_byte), .rx_vld(rx_vld),
        .frame_data(frame_data), .frame_len(frame_len), .frame_vld(frame_vld),
        .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass = 0;

    // observed output pulses
    bit              obs_kind[$];
    logic [2:0]      obs_code[$];
    logic [7:0]      obs_len[$];
    logic [8*ML-1:0] obs_data[$];
    int              both_high = 0;

    always @(negedge sys_clk) begin
        if (frame_vld || frame_err) begin
            obs_kind.push_back(frame_vld);
            obs_code.push_back(err_code);
            obs_len.push_back(frame_len);
            obs_data.push_back(frame_data);
        end
        if (frame_vld && frame_err) both_high++;
    end

    // reference model: phase 0 hunting, 1 one delimiter seen, 2 in payload, 3 delimiter pending
    int              m_phase = 0;
    logic [7:0]      m_pay[$];
    logic [7:0]      m_good[$];
    int              m_good_len = 0;
    bit              exp_kind[$];
    logic [2:0]      exp_code[$];
    int              exp_len[$];
    logic [8*ML-1:0] exp_data[$];

    function automatic logic [8*ML-1:0] pack_good();
        logic [8*ML-1:0] v = '0;
        foreach (m_good[i]) v[8*i +: 8] = m_good[i];
        return v;
    endfunction

    task automatic m_emit_err(input logic [2:0] code);
        exp_kind.push_back(1'b0); exp_code.push_back(code);
        exp_len.push_back(m_good_len); exp_data.push_back(pack_good());
    endtask

    task automatic m_emit_ok(input int len);
        m_good = m_pay; m_good_len = len;
        exp_kind.push_back(1'b1); exp_code.push_back(3'd0);
        exp_len.push_back(len); exp_data.push_back(pack_good());
    endtask

    task automatic m_finish();
`ifdef UART_FRAME_RX_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        foreach (m_pay[i]) x ^= m_pay[i];
        if (m_pay.size() <= 1) m_emit_err(3'd3);
        else if (x != 8'h00)   m_emit_err(3'd4);
        else                   m_emit_ok(m_pay.size() - 1);
`else
        if (m_pay.size() == 0) m_emit_err(3'd3);
        else                   m_emit_ok(m_pay.size());
`endif
    endtask

    task automatic m_feed(input logic [7:0] b);
        case (m_phase)
            0: if (b == DL) m_phase = 1;
            1: if (b == DL) begin m_phase = 2; m_pay.delete(); end else m_phase = 0;
            2: if (b == DL) m_phase = 3;
               else if (m_pay.size() >= ML) begin m_emit_err(3'd1); m_phase = 0; end
               else m_pay.push_back(b);
            default:
               if (b == DL) begin m_phase = 0; m_finish(); end
               else if (m_pay.size() + 2 > ML) begin m_emit_err(3'd1); m_phase = 0; end
               else begin m_pay.push_back(DL); m_pay.push_back(b); m_phase = 2; end
        endcase
    endtask

    task automatic m_silence();
        if (m_phase >= 2) m_emit_err(3'd2);
        m_phase = 0;
    endtask

    // one strobe followed by g (>=1) idle cycles; g >= TO is a silence the model sees too
    task automatic xfer(input logic [7:0] b, input int g);
        m_feed(b);
        @(negedge sys_clk); rx_byte = b; rx_vld = 1'b1;
        @(negedge sys_clk); rx_vld = 1'b0;
        repeat (g - 1) @(negedge sys_clk);
        if (g >= TO) m_silence();
    endtask

    task automatic xfer_str(input string s, input int g);
        for (int i = 0; i < s.len(); i++) xfer(s[i], g);
    endtask

    task automatic clear_obs();
        obs_kind.delete(); obs_code.delete(); obs_len.delete(); obs_data.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        n_checks++; if (frame_vld !== 1'b0) $display("FAIL rst_vld got %b want 0", frame_vld); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL rst_err got %b want 0", frame_err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        n_checks++; if (frame_data !== '0) $display("FAIL rst_data got %0h want 0", frame_data); else n_pass++;
        n_checks++; if (frame_len !== 8'd0) $display("FAIL rst_len got %0d want 0", frame_len); else n_pass++;
        n_checks++; if (err_code !== 3'd0) $display("FAIL rst_code got %0d want 0", err_code); else n_pass++;
    endtask

    task automatic test_basic();
        clear_obs();
        xfer_str("&&AB&", 20);
        m_feed(DL);
        @(negedge sys_clk); rx_byte = DL; rx_vld = 1'b1;
        @(negedge sys_clk); rx_vld = 1'b0;
        n_checks++; if (frame_vld !== 1'b0) $display("FAIL basic_early got %b want 0", frame_vld); else n_pass++;
        @(negedge sys_clk);
        n_checks++; if (frame_vld !== 1'b1) $display("FAIL basic_latency got %b want 1", frame_vld); else n_pass++;
        n_checks++; if (frame_len !== 8'd2) $display("FAIL basic_len got %0d want 2", frame_len); else n_pass++;
        n_checks++; if (frame_data[15:0] !== 16'h4241) $display("FAIL basic_data got %h want 4241", frame_data[15:0]); else n_pass++;
        repeat (20) @(negedge sys_clk);
        n_checks++; if (obs_kind.size() != 1 || obs_kind[0] !== 1'b1)
            $display("FAIL basic_pulses got %0d pulses want 1 valid", obs_kind.size()); else n_pass++;
    endtask

    task automatic test_embedded();
        clear_obs();
        xfer_str("&&a&b&&", 3);
        repeat (4) @(negedge sys_clk);
        n_checks++; if (obs_kind.size() != 1 || obs_kind[0] !== 1'b1)
            $display("FAIL emb_pulses got %0d pulses want 1 valid", obs_kind.size());
        else n_pass++;
        if (obs_kind.size() == 1) begin
            n_checks++; if (obs_len[0] !== 8'd3) $display("FAIL emb_len got %0d want 3", obs_len[0]); else n_pass++;
            n_checks++; if (obs_data[0][23:0] !== 24'h622661) $display("FAIL emb_data got %h want 622661", obs_data[0][23:0]); else n_pass++;
        end
    endtask

    task automatic test_empty();
        clear_obs();
        xfer_str("&&&&", 3);
        repeat (4) @(negedge sys_clk);
        n_checks++; if (obs_kind.size() != 1 || obs_kind[0] !== 1'b0 || obs_code[0] !== 3'd3)
            $display("FAIL empty_err got %0d pulses want one err code 3", obs_kind.size());
        else n_pass++;
        n_checks++; if (frame_len !== 8'd3 || frame_data[23:0] !== 24'h622661)
            $display("FAIL empty_hold got len %0d data %h want len 3 data 622661", frame_len, frame_data[23:0]);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        clear_obs();
        xfer_str("&&", 2);
        for (int i = 0; i < ML; i++) begin
            b = 8'h30 + 8'($urandom_range(0, 40));
            xfer(b, 1);
        end
        n_checks++; if (obs_kind.size() != 0) $display("FAIL ovf_early got %0d pulses want 0", obs_kind.size()); else n_pass++;
        xfer(8'h58, 1);
        n_checks++; if (frame_err !== 1'b1 || err_code !== 3'd1)
            $display("FAIL ovf_err got err %b code %0d want 1 code 1", frame_err, err_code);
        else n_pass++;
        xfer_str("&&Z&&", 2);
        repeat (4) @(negedge sys_clk);
        n_checks++; if (frame_len !== 8'd1 || frame_data[7:0] !== 8'h5A)
            $display("FAIL ovf_next got len %0d byte %h want len 1 byte 5a", frame_len, frame_data[7:0]);
        else n_pass++;
    endtask

    task automatic test_timeout();
        clear_obs();
        xfer_str("&&X", 2);
        xfer(8'h59, TO + 10);
        n_checks++; if (obs_kind.size() != 1 || obs_kind[0] !== 1'b0 || obs_code[0] !== 3'd2)
            $display("FAIL tmo_err got %0d pulses want one err code 2", obs_kind.size());
        else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL tmo_busy got %b want 0", busy); else n_pass++;
        clear_obs();
        xfer_str("&&", 2);
        xfer(8'h41, TO - 1);
        xfer_str("B&&", 2);
        repeat (4) @(negedge sys_clk);
        n_checks++; if (obs_kind.size() != 1 || frame_len !== 8'd2 || frame_data[15:0] !== 16'h4241)
            $display("FAIL tmo_edge got %0d pulses len %0d want 1 pulse len 2", obs_kind.size(), frame_len);
        else n_pass++;
        clear_obs();
        xfer_str("xx&q&&Q&&", 2);
        repeat (4) @(negedge sys_clk);
        n_checks++; if (obs_kind.size() != 1 || frame_len !== 8'd1 || frame_data[7:0] !== 8'h51)
            $display("FAIL tmo_resync got %0d pulses len %0d byte %h want 1 len 1 byte 51", obs_kind.size(), frame_len, frame_data[7:0]);
        else n_pass++;
    endtask

`ifdef UART_FRAME_RX_CHECKSUM_EN
    task automatic test_checksum();
        clear_obs();
        xfer_str("&&", 2); xfer(8'h01, 2); xfer(8'h02, 2); xfer(8'h03, 2); xfer_str("&&", 2);
        repeat (4) @(negedge sys_clk);
        n_checks++; if (frame_len !== 8'd2 || frame_data[23:0] !== 24'h030201)
            $display("FAIL cks_ok got len %0d data %h want len 2 data 030201", frame_len, frame_data[23:0]);
        else n_pass++;
        clear_obs();
        xfer_str("&&", 2); xfer(8'h01, 2); xfer(8'h02, 2); xfer(8'h04, 2); xfer_str("&&", 2);
        repeat (4) @(negedge sys_clk);
        n_checks++; if (obs_kind.size() != 1 || obs_kind[0] !== 1'b0 || obs_code[0] !== 3'd4)
            $display("FAIL cks_bad got %0d pulses want one err code 4", obs_kind.size());
        else n_pass++;
        clear_obs();
        xfer_str("&&", 2); xfer(8'h05, 2); xfer_str("&&", 2);
        repeat (4) @(negedge sys_clk);
        n_checks++; if (obs_kind.size() != 1 || obs_kind[0] !== 1'b0 || obs_code[0] !== 3'd3)
            $display("FAIL cks_only got %0d pulses want one err code 3", obs_kind.size());
        else n_pass++;
    endtask
`endif

    task automatic test_reset_mid();
        clear_obs();
        xfer_str("&&AB", 2);
        @(negedge sys_clk); sys_rst_n = 1'b0;
        m_phase = 0; m_pay.delete(); m_good.delete(); m_good_len = 0;
        @(negedge sys_clk);
        n_checks++; if (busy !== 1'b0 || frame_data !== '0 || frame_len !== 8'd0 ||
                        frame_vld !== 1'b0 || frame_err !== 1'b0 || err_code !== 3'd0)
            $display("FAIL midrst_outs got busy %b len %0d vld %b err %b code %0d want all 0",
                     busy, frame_len, frame_vld, frame_err, err_code);
        else n_pass++;
        repeat (2) @(negedge sys_clk); sys_rst_n = 1'b1;
        repeat (6) @(negedge sys_clk);
        n_checks++; if (obs_kind.size() != 0) $display("FAIL midrst_pulse got %0d pulses want 0", obs_kind.size()); else n_pass++;
    endtask

    task automatic test_random();
        int         len;
        bit         ok;
        logic [7:0] pl[$];
        logic [7:0] x;
        clear_obs();
        exp_kind.delete(); exp_code.delete(); exp_len.delete(); exp_data.delete();
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) xfer(($urandom_range(0, 3) == 0) ? DL : 8'($urandom), $urandom_range(1, 3));
            xfer_str("&&", $urandom_range(1, 3));
            len = $urandom_range(0, ML + 2);
            pl.delete(); x = 8'h00;
            for (int i = 0; i < len; i++) begin
                pl.push_back(($urandom_range(0, 7) == 0) ? DL : 8'($urandom));
                if (i < len - 1) x ^= pl[i];
            end
            if (len > 0 && $urandom_range(0, 1) == 1) pl[len - 1] = x;
            foreach (pl[i]) xfer(pl[i], ($urandom_range(0, 60) == 0) ? TO + 5 : $urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) xfer(8'h2E, TO + 5);
            else xfer_str("&&", $urandom_range(1, 3));
        end
        repeat (10) @(negedge sys_clk);
        n_checks++; if (obs_kind.size() != exp_kind.size())
            $display("FAIL rnd_count got %0d pulses want %0d", obs_kind.size(), exp_kind.size());
        else n_pass++;
        for (int e = 0; e < exp_kind.size() && e < obs_kind.size(); e++) begin
            n_checks++; if (obs_kind[e] !== exp_kind[e] || (!exp_kind[e] && obs_code[e] !== exp_code[e]))
                $display("FAIL rnd_kind[%0d] got vld %b code %0d want vld %b code %0d", e, obs_kind[e], obs_code[e], exp_kind[e], exp_code[e]);
            else n_pass++;
            n_checks++; if (obs_len[e] !== 8'(exp_len[e]))
                $display("FAIL rnd_len[%0d] got %0d want %0d", e, obs_len[e], exp_len[e]);
            else n_pass++;
            ok = 1'b1;
            for (int i = 0; i < exp_len[e]; i++) if (obs_data[e][8*i +: 8] !== exp_data[e][8*i +: 8]) ok = 1'b0;
            n_checks++; if (!ok) $display("FAIL rnd_data[%0d] got %h want %h", e, obs_data[e][63:0], exp_data[e][63:0]);
            else n_pass++;
        end
        n_checks++; if (both_high != 0) $display("FAIL vld_err_overlap got %0d cycles want 0", both_high); else n_pass++;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
`ifdef UART_FRAME_RX_CHECKSUM_EN
        test_checksum();
`else
        test_basic();
        test_embedded();
        test_empty();
        test_overflow();
        test_timeout();
`endif
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
